// File: rtl/bitslip_align.sv
// Word aligner for a deserializer with a bitslip input. It hunts for
// TRAIN_PATTERN by issuing bitslip pulses and confirms alignment over several
// consecutive words. Once locked it forwards the parallel data and watches
// for loss of alignment.
module bitslip_align #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'h0E),
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = '0,
  parameter int                    SETTLE_CYCLES = 3,
  parameter int                    LOCK_COUNT    = 4,
  parameter int                    LOSS_COUNT    = 2
) (
  input  logic                          clkdiv,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         q,
  input  logic                          train_en,
  input  logic                          restart,
  output logic                          bitslip,
  output logic                          locked,
  output logic                          fail,
  output logic [$clog2(DATA_WIDTH):0]   slip_count,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid
);

  localparam int SCW = $clog2(DATA_WIDTH) + 1;
  localparam int MW  = $clog2(LOCK_COUNT + 1);
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int LW  = $clog2(LOSS_COUNT + 1);

  localparam logic [SCW-1:0] SLIP_MAX    = SCW'(DATA_WIDTH);
  localparam logic [MW-1:0]  LOCK_LAST   = MW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0]  LOSS_LAST   = LW'(LOSS_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
  } state_t;

  state_t                r_state;
  logic                  r_bitslip;
  logic                  r_locked;
  logic                  r_fail;
  logic [SCW-1:0]        r_slip_cnt;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic [MW-1:0]         r_match_cnt;
  logic [SW-1:0]         r_settle_cnt;
  logic [LW-1:0]         r_loss_cnt;

  logic w_is_pattern;
  logic w_is_idle;

  // Saturating slip counter increment: the count never wraps past DATA_WIDTH.
  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
    return (v >= SLIP_MAX) ? SLIP_MAX : v + 1'b1;
  endfunction

  // Word classification shared by the search and loss-of-lock checks.
  always_comb begin
    w_is_pattern = (q == TRAIN_PATTERN);
    w_is_idle    = (q == IDLE_WORD);
  end

  // Alignment FSM with all outputs registered; restart outranks every state.
  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bitslip    <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_slip_cnt   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_match_cnt  <= '0;
      r_settle_cnt <= '0;
      r_loss_cnt   <= '0;
    end else if (restart) begin
      r_state      <= S_IDLE;
      r_bitslip    <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_slip_cnt   <= '0;
      r_data_valid <= 1'b0;
      r_match_cnt  <= '0;
      r_settle_cnt <= '0;
      r_loss_cnt   <= '0;
    end else begin
      // The pulse is one cycle wide by construction: it is only ever set on
      // entry to SLIP and SLIP always leaves after one cycle.
      r_bitslip    <= 1'b0;
      r_data_valid <= r_locked;
      case (r_state)
        S_IDLE: begin
          if (train_en && !w_is_idle) begin
            r_state     <= S_SEARCH;
            r_match_cnt <= '0;
          end
        end
        S_SEARCH: begin
          if (w_is_pattern) begin
            if (r_match_cnt == LOCK_LAST) begin
              r_state     <= S_LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
              r_loss_cnt  <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end else if (w_is_idle) begin
            r_match_cnt <= '0;
          end else begin
            r_match_cnt <= '0;
            if (r_slip_cnt == SLIP_MAX) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state    <= S_SLIP;
              r_bitslip  <= 1'b1;
              r_slip_cnt <= sat_inc(r_slip_cnt);
            end
          end
        end
        S_SLIP: begin
          r_state      <= S_SETTLE;
          r_settle_cnt <= '0;
        end
        S_SETTLE: begin
          // Deserializer output is in flux after a slip, so q is ignored here.
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_SEARCH;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          r_data_out <= q;
          // Idle words neither count toward loss nor break lock.
          if (train_en && !w_is_pattern && !w_is_idle) begin
            if (r_loss_cnt == LOSS_LAST) begin
              r_state     <= S_SEARCH;
              r_locked    <= 1'b0;
              r_slip_cnt  <= '0;
              r_loss_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_loss_cnt <= r_loss_cnt + 1'b1;
            end
          end else begin
            r_loss_cnt <= '0;
          end
        end
        S_FAIL: begin
          r_fail <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bitslip    = r_bitslip;
  assign locked     = r_locked;
  assign fail       = r_fail;
  assign slip_count = r_slip_cnt;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

endmodule

// File: tb/tb_bitslip_align.sv
// Directed bench for bitslip_align with a deserializer model that rotates the
// source word right by one bit for every bitslip pulse it sees.
module tb_bitslip_align;

  logic       clkdiv = 1'b0;
  logic       rst_n;
  logic [7:0] q;
  logic       train_en;
  logic       restart;
  logic       bitslip;
  logic       locked;
  logic       fail;
  logic [3:0] slip_count;
  logic [7:0] data_out;
  logic       data_valid;

  always #5 clkdiv = ~clkdiv;

  bitslip_align #(
    .DATA_WIDTH(8), .TRAIN_PATTERN(8'h0E), .IDLE_WORD(8'h00),
    .SETTLE_CYCLES(3), .LOCK_COUNT(4), .LOSS_COUNT(2)
  ) dut (
    .clkdiv(clkdiv), .rst_n(rst_n), .q(q), .train_en(train_en),
    .restart(restart), .bitslip(bitslip), .locked(locked), .fail(fail),
    .slip_count(slip_count), .data_out(data_out), .data_valid(data_valid)
  );

  int         vectors = 0;
  int         errs = 0;
  int         cyc = 0;
  int         nslips = 0;
  int         pulses = 0;
  int         last_pulse = -1;
  int         t;
  logic [7:0] src = 8'h00;
  logic [3:0] slip_q[$];
  logic [7:0] data_q[$];

  function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < (n % 8); i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: queue the word the DUT will capture if locked, clock, then
  // score pulses and captured data, and advance the deserializer model.
  task automatic tick();
    logic [3:0] exp_sc;
    logic [7:0] exp_d;
    if (locked === 1'b1 && restart === 1'b0 && rst_n === 1'b1) data_q.push_back(q);
    @(posedge clkdiv);
    #1;
    cyc++;
    if (bitslip === 1'b1) begin
      pulses++;
      if (last_pulse >= 0) check("pulse_spacing", 32'(cyc - last_pulse), 32'd5);
      last_pulse = cyc;
      vectors++;
      assert (slip_q.size() > 0) else begin
        errs++;
        $error("FAIL unexpected_pulse: observed pulse at cycle %0d expected none", cyc);
      end
      if (slip_q.size() > 0) begin
        exp_sc = slip_q.pop_front();
        check("slip_count_at_pulse", 32'(slip_count), 32'(exp_sc));
      end
      nslips++;
    end
    if (data_q.size() > 0) begin
      exp_d = data_q.pop_front();
      check("data_out", 32'(data_out), 32'(exp_d));
    end
    q = rotr(src, nslips);
  endtask

  task automatic start_case(input logic [7:0] s, input int nexp);
    nslips = 0;
    pulses = 0;
    last_pulse = -1;
    slip_q.delete();
    for (int i = 1; i <= nexp; i++) slip_q.push_back(4'(i));
    src = s;
    q = rotr(src, nslips);
  endtask

  initial begin
    rst_n = 1'b0;
    train_en = 1'b0;
    restart = 1'b0;
    q = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_bitslip", 32'(bitslip), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_slip_count", 32'(slip_count), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    rst_n = 1'b1;

    // Idle link: stays in IDLE
    train_en = 1'b1;
    start_case(8'h00, 0);
    for (int i = 0; i < 10; i++) tick();
    check("idle_locked", 32'(locked), 32'd0);
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_bitslip", 32'(bitslip), 32'd0);

    // Already aligned
    start_case(8'h0E, 0);
    for (int i = 0; i < 4; i++) tick();
    check("aligned_locked_early", 32'(locked), 32'd0);
    tick();
    check("aligned_locked", 32'(locked), 32'd1);
    check("aligned_dv_lag", 32'(data_valid), 32'd0);
    check("aligned_slip_count", 32'(slip_count), 32'd0);
    tick();
    check("aligned_dv", 32'(data_valid), 32'd1);
    check("aligned_pulses", 32'(pulses), 32'd0);

    // Single bad word keeps lock; two consecutive drop it
    src = 8'h33; q = rotr(src, nslips);
    tick();
    check("loss_single_locked", 32'(locked), 32'd1);
    src = 8'h0E; q = rotr(src, nslips);
    tick();
    check("loss_recover_locked", 32'(locked), 32'd1);
    src = 8'h33; q = rotr(src, nslips);
    tick();
    check("loss_first_locked", 32'(locked), 32'd1);
    tick();
    check("loss_dropped", 32'(locked), 32'd0);
    check("loss_slip_count", 32'(slip_count), 32'd0);
    src = 8'h0E; q = rotr(src, nslips);
    for (int i = 0; i < 3; i++) tick();
    check("relock_early", 32'(locked), 32'd0);
    tick();
    check("relock", 32'(locked), 32'd1);

    // Restart from LOCKED
    train_en = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_locked", 32'(locked), 32'd0);
    check("restart_dv", 32'(data_valid), 32'd0);
    tick();
    check("restart_dv_hold", 32'(data_valid), 32'd0);

    // Misaligned by three bits
    start_case(8'h70, 3);
    train_en = 1'b1;
    t = 0;
    while (locked !== 1'b1 && t < 40) begin tick(); t++; end
    check("slip3_lock_cycle", 32'(t), 32'd20);
    check("slip3_pulses", 32'(pulses), 32'd3);
    check("slip3_slip_count", 32'(slip_count), 32'd3);

    // No alignment exists
    train_en = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    start_case(8'h55, 8);
    train_en = 1'b1;
    t = 0;
    while (fail !== 1'b1 && t < 100) begin tick(); t++; end
    check("fail_flag", 32'(fail), 32'd1);
    check("fail_pulses", 32'(pulses), 32'd8);
    check("fail_slip_count", 32'(slip_count), 32'd8);
    for (int i = 0; i < 20; i++) tick();
    check("fail_sticky", 32'(fail), 32'd1);
    check("fail_no_more_pulses", 32'(pulses), 32'd8);
    check("fail_locked", 32'(locked), 32'd0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    train_en = 1'b0;
    check("fail_restart_fail", 32'(fail), 32'd0);
    check("fail_restart_slip", 32'(slip_count), 32'd0);
    check("fail_restart_bitslip", 32'(bitslip), 32'd0);

    // Asynchronous reset during SETTLE
    start_case(8'h70, 1);
    train_en = 1'b1;
    t = 0;
    while (pulses == 0 && t < 20) begin tick(); t++; end
    check("settle_rst_pulse_seen", 32'(pulses), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_slip_count", 32'(slip_count), 32'd0);
    check("async_rst_bitslip", 32'(bitslip), 32'd0);
    check("async_rst_data_out", 32'(data_out), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    tick();
    tick();
    check("rst_held_pulses", 32'(pulses), 32'd1);
    rst_n = 1'b1;
    start_case(8'h0E, 0);
    t = 0;
    while (locked !== 1'b1 && t < 20) begin tick(); t++; end
    check("post_rst_lock_cycle", 32'(t), 32'd5);
    check("post_rst_pulses", 32'(pulses), 32'd0);
    check("post_rst_slip_count", 32'(slip_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
